// File: rtl/wb_pkg.sv
// Shared writeback-stage definitions: source-select codes, halt FSM states
// and the control fields captured in the MEM/WB register.
package wb_pkg;

  localparam logic [1:0] WB_SEL_MEM = 2'b00;
  localparam logic [1:0] WB_SEL_ALU = 2'b01;
  localparam logic [1:0] WB_SEL_PC2 = 2'b10;
  localparam logic [1:0] WB_SEL_IMM = 2'b11;

  typedef enum logic {
    WB_RUN,
    WB_HALTED
  } wb_state_t;

  // Width-independent captured fields; data buses and rd are held alongside
  // in the stage because their widths are per-instance parameters.
  typedef struct packed {
    logic [1:0] sel;
    logic       byte_ld;
    logic       byte_signed;
    logic       regwrite;
    logic       halt;
  } mem_wb_t;

endpackage

// File: rtl/wb_src_mux.sv
// Writeback source select with byte-load extension. Purely combinational so
// the EX forwarding path can reuse it.
module wb_src_mux
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic [1:0]        i_sel,
  input  logic [DATA_W-1:0] i_pc_plus2,
  input  logic [DATA_W-1:0] i_alu,
  input  logic [DATA_W-1:0] i_mem,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_byte_ld,
  input  logic              i_byte_signed,
  output logic [DATA_W-1:0] o_data
);

  logic [DATA_W-1:0] w_mem_ext;

  // Byte extension: fill with the sign bit (or zero), then overlay the low byte
  always_comb begin
    w_mem_ext      = {DATA_W{i_byte_signed & i_mem[7]}};
    w_mem_ext[7:0] = i_mem[7:0];
  end

  // Source select; byte_ld only affects the memory source
  always_comb begin
    o_data = '0;
    unique case (i_sel)
      WB_SEL_MEM: o_data = i_byte_ld ? w_mem_ext : i_mem;
      WB_SEL_ALU: o_data = i_alu;
      WB_SEL_PC2: o_data = i_pc_plus2;
      WB_SEL_IMM: o_data = i_imm;
      default:    o_data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with writeback source select, stall/flush
// handling, sticky halt FSM and saturating retired-instruction counter.
module wb_stage_pipe
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned REG_ADDR_W = 3,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  in_stall,
  input  logic                  in_flush,
  input  logic [1:0]            in_sel,
  input  logic [DATA_W-1:0]     in_pc_plus2,
  input  logic [DATA_W-1:0]     in_alu,
  input  logic [DATA_W-1:0]     in_mem,
  input  logic [DATA_W-1:0]     in_imm,
  input  logic                  in_byte_ld,
  input  logic                  in_byte_signed,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_regwrite,
  input  logic                  in_halt,
  output logic                  wb_valid,
  output logic                  wb_we,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  halted,
  output logic [CNT_W-1:0]      retire_count
);

  wb_state_t             r_state;
  wb_state_t             w_state_nxt;
  logic                  r_valid;
  mem_wb_t               r_ctrl;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_pc_plus2;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_mem;
  logic [DATA_W-1:0]     r_imm;
  logic [CNT_W-1:0]      r_count;
  logic [DATA_W-1:0]     w_mux;
  logic                  w_block;
  logic                  w_capture;

  // Halt FSM next state: a retiring HALT moves to HALTED, which is sticky
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == WB_RUN && r_valid && r_ctrl.halt) w_state_nxt = WB_HALTED;
  end

  // HALTED never leaves, so "next is HALTED" covers both the halted state
  // and the transition cycle, whose inputs are discarded.
  assign w_block   = (w_state_nxt == WB_HALTED);
  assign w_capture = ~w_block & ~in_flush & ~in_stall;

  // Halt FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= WB_RUN;
    else        r_state <= w_state_nxt;
  end

  // MEM/WB register: reset > halted/halting > flush > stall > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_ctrl     <= '0;
      r_rd       <= '0;
      r_pc_plus2 <= '0;
      r_alu      <= '0;
      r_mem      <= '0;
      r_imm      <= '0;
    end else if (w_block || in_flush) begin
      r_valid <= 1'b0;
    end else if (!in_stall) begin
      r_valid            <= in_valid;
      r_ctrl.sel         <= in_sel;
      r_ctrl.byte_ld     <= in_byte_ld;
      r_ctrl.byte_signed <= in_byte_signed;
      r_ctrl.regwrite    <= in_regwrite;
      r_ctrl.halt        <= in_halt;
      r_rd               <= in_rd;
      r_pc_plus2         <= in_pc_plus2;
      r_alu              <= in_alu;
      r_mem              <= in_mem;
      r_imm              <= in_imm;
    end
  end

  // Retired-instruction counter, saturating at all-ones
  always_ff @(posedge clk) begin
    if (!rst_n)                                         r_count <= '0;
    else if (w_capture && in_valid && (r_count != '1))  r_count <= r_count + CNT_W'(1);
  end

  wb_src_mux #(
    .DATA_W(DATA_W)
  ) u_src_mux (
    .i_sel         (r_ctrl.sel),
    .i_pc_plus2    (r_pc_plus2),
    .i_alu         (r_alu),
    .i_mem         (r_mem),
    .i_imm         (r_imm),
    .i_byte_ld     (r_ctrl.byte_ld),
    .i_byte_signed (r_ctrl.byte_signed),
    .o_data        (w_mux)
  );

  assign wb_valid     = r_valid;
  assign wb_we        = r_valid & r_ctrl.regwrite & ~r_ctrl.halt;
  assign wb_rd        = r_rd;
  assign wb_data      = r_valid ? w_mux : '0;
  assign halted       = (r_state == WB_HALTED);
  assign retire_count = r_count;

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Scoreboard bench for wb_stage_pipe: the driver pushes hand-computed
// expectations per cycle, an independent monitor pops and compares them.
module tb_wb_stage_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_stall, in_flush;
  logic [1:0]  in_sel;
  logic [15:0] in_pc_plus2, in_alu, in_mem, in_imm;
  logic        in_byte_ld, in_byte_signed;
  logic [2:0]  in_rd;
  logic        in_regwrite, in_halt;

  logic        wb_valid, wb_we, halted;
  logic [2:0]  wb_rd;
  logic [15:0] wb_data;
  logic [15:0] retire_count;

  logic        s_valid, s_we, s_halted;
  logic [2:0]  s_rd;
  logic [15:0] s_data;
  logic [3:0]  s_count;

  typedef struct {
    string nm;
    int    valid, we, rd, data, hlt, cnt, cnt4;  // rd/cnt4 = -1: not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  wb_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stall(in_stall),
    .in_flush(in_flush), .in_sel(in_sel), .in_pc_plus2(in_pc_plus2),
    .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm), .in_byte_ld(in_byte_ld),
    .in_byte_signed(in_byte_signed), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_halt(in_halt), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .halted(halted), .retire_count(retire_count)
  );

  wb_stage_pipe #(.DATA_W(16), .REG_ADDR_W(3), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_stall(in_stall),
    .in_flush(in_flush), .in_sel(in_sel), .in_pc_plus2(in_pc_plus2),
    .in_alu(in_alu), .in_mem(in_mem), .in_imm(in_imm), .in_byte_ld(in_byte_ld),
    .in_byte_signed(in_byte_signed), .in_rd(in_rd), .in_regwrite(in_regwrite),
    .in_halt(in_halt), .wb_valid(s_valid), .wb_we(s_we), .wb_rd(s_rd),
    .wb_data(s_data), .halted(s_halted), .retire_count(s_count)
  );

  task automatic chk(input string nm, input string fld, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  // Monitor: compares outputs just after each edge for which an expectation exists
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "wb_valid", int'(wb_valid), e.valid);
        chk(e.nm, "wb_we", int'(wb_we), e.we);
        if (e.rd >= 0) chk(e.nm, "wb_rd", int'(wb_rd), e.rd);
        chk(e.nm, "wb_data", int'(wb_data), e.data);
        chk(e.nm, "halted", int'(halted), e.hlt);
        chk(e.nm, "retire_count", int'(retire_count), e.cnt);
        if (e.cnt4 >= 0) chk(e.nm, "retire_count_sat", int'(s_count), e.cnt4);
      end
    end
  end

  // Advance one edge with the currently driven inputs, queueing the
  // expected post-edge outputs, then return at the following negedge.
  task automatic tick(input string nm, input int v, input int we, input int rd,
                      input int data, input int hlt, input int cnt, input int cnt4 = -1);
    exp_t e;
    @(posedge clk);
    e.nm = nm; e.valid = v; e.we = we; e.rd = rd; e.data = data;
    e.hlt = hlt; e.cnt = cnt; e.cnt4 = cnt4;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; in_stall = 0; in_flush = 0; in_sel = 2'b00;
    in_pc_plus2 = '0; in_alu = '0; in_mem = '0; in_imm = '0;
    in_byte_ld = 0; in_byte_signed = 0; in_rd = '0; in_regwrite = 0; in_halt = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 0;
    @(negedge clk);
    tick("reset", 0, 0, 0, 0, 0, 0, 0);

    // Select paths
    rst_n = 1;
    in_valid = 1; in_regwrite = 1; in_rd = 3;
    in_sel = 2'b01; in_alu = 16'h1234;
    tick("sel_alu", 1, 1, 3, 16'h1234, 0, 1);
    in_sel = 2'b10; in_pc_plus2 = 16'h0042;
    tick("sel_pc2", 1, 1, 3, 16'h0042, 0, 2);
    in_sel = 2'b11; in_imm = 16'hBEEF;
    tick("sel_imm", 1, 1, 3, 16'hBEEF, 0, 3);

    // Byte loads
    in_sel = 2'b00; in_mem = 16'h12F0; in_rd = 5; in_byte_ld = 1; in_byte_signed = 1;
    tick("lb_signed", 1, 1, 5, 16'hFFF0, 0, 4);
    in_byte_signed = 0;
    tick("lb_unsigned", 1, 1, 5, 16'h00F0, 0, 5);
    in_byte_ld = 0;
    tick("lw", 1, 1, 5, 16'h12F0, 0, 6);
    in_sel = 2'b01; in_alu = 16'h5678; in_byte_ld = 1; in_byte_signed = 1;
    tick("byte_ignored_alu", 1, 1, 5, 16'h5678, 0, 7);
    in_byte_ld = 0; in_byte_signed = 0; in_regwrite = 0;
    tick("no_regwrite", 1, 0, 5, 16'h5678, 0, 8);
    in_valid = 0; in_regwrite = 1;
    tick("bubble", 0, 0, 5, 0, 0, 8);

    // Stall and flush
    in_valid = 1; in_rd = 2; in_alu = 16'h00AA;
    tick("cap_aa", 1, 1, 2, 16'h00AA, 0, 9);
    in_stall = 1; in_alu = 16'hFFFF; in_rd = 7; in_sel = 2'b11; in_imm = 16'h1111;
    for (int i = 0; i < 3; i++) tick("stall_hold", 1, 1, 2, 16'h00AA, 0, 9);
    in_flush = 1;
    tick("flush_over_stall", 0, 0, -1, 0, 0, 9);
    in_flush = 0; in_stall = 0; in_sel = 2'b01; in_alu = 16'h0011; in_rd = 1;
    tick("after_flush", 1, 1, 1, 16'h0011, 0, 10);

    // Halt
    in_halt = 1; in_alu = 16'h7777; in_rd = 4;
    tick("halt_retire", 1, 0, 4, 16'h7777, 0, 11);
    in_halt = 0; in_alu = 16'h3333;
    tick("halt_transition", 0, 0, -1, 0, 1, 11);
    tick("halted_frozen", 0, 0, -1, 0, 1, 11);
    rst_n = 0;
    tick("reset_from_halt", 0, 0, 0, 0, 0, 0, 0);

    // Reset during a stall with a valid entry
    rst_n = 1; in_alu = 16'h5555; in_rd = 6;
    tick("cap_55", 1, 1, 6, 16'h5555, 0, 1);
    in_stall = 1;
    tick("stall_55", 1, 1, 6, 16'h5555, 0, 1);
    rst_n = 0;
    tick("reset_in_stall", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1; in_stall = 0; in_alu = 16'h0101; in_rd = 1;
    tick("run_after_reset", 1, 1, 1, 16'h0101, 0, 1, 1);

    // Counter saturation on the CNT_W=4 instance
    rst_n = 0;
    tick("reset_sat", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1;
    for (int i = 1; i <= 20; i++) begin
      in_alu = 16'(i);
      tick("sat_run", 1, 1, 1, i, 0, i, (i > 15) ? 15 : i);
    end
    in_valid = 0;
    tick("sat_hold", 0, 0, 1, 0, 0, 20, 15);

    idle();
    repeat (3) @(negedge clk);
    chk("scoreboard", "pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
